// File: rtl/ula_pkg.sv
// Shared constants for the ULA and its arbiter: opcodes, FSM encoding, widths.
package ula_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned SEL_W  = 3;

  localparam logic [SEL_W-1:0] ADD   = 3'b000;
  localparam logic [SEL_W-1:0] SUB   = 3'b001;
  localparam logic [SEL_W-1:0] COMP  = 3'b010;
  localparam logic [SEL_W-1:0] IGUAL = 3'b011;
  localparam logic [SEL_W-1:0] MAIOR = 3'b100;
  localparam logic [SEL_W-1:0] MENOR = 3'b101;
  localparam logic [SEL_W-1:0] AND   = 3'b110;
  localparam logic [SEL_W-1:0] OR    = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

// File: rtl/ULA.sv
// Combinational 4-bit ULA; all arithmetic wraps modulo 16.
module ULA
  import ula_pkg::*;
(
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [SEL_W-1:0]  sel,
  output logic [DATA_W-1:0] result,
  output logic              status
);

  // Opcode decode; MAIOR/MENOR return the larger/smaller operand plus the compare flag.
  always_comb begin
    result = '0;
    status = 1'b0;
    case (sel)
      ADD:   result = DATA_W'(a + b);
      SUB:   result = DATA_W'(a - b);
      COMP:  result = DATA_W'(~b + DATA_W'(1));
      IGUAL: status = (a == b);
      MAIOR: begin
        result = (a > b) ? a : b;
        status = (a > b);
      end
      MENOR: begin
        result = (a < b) ? a : b;
        status = (a < b);
      end
      AND:   result = a & b;
      OR:    result = a | b;
      default: begin
        result = '0;
        status = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/ula_arbiter.sv
// Two-requester arbiter around the single shared ULA with registered req/ack handshake.
module ula_arbiter
  import ula_pkg::*;
#(
  parameter int unsigned FAIR = 1
) (
  input  logic              clockArbiter,
  input  logic              resetArbiter,
  input  logic              req0Arbiter,
  input  logic [DATA_W-1:0] a0Arbiter,
  input  logic [DATA_W-1:0] b0Arbiter,
  input  logic [SEL_W-1:0]  sel0Arbiter,
  input  logic              req1Arbiter,
  input  logic [DATA_W-1:0] a1Arbiter,
  input  logic [DATA_W-1:0] b1Arbiter,
  input  logic [SEL_W-1:0]  sel1Arbiter,
  output logic              ack0Arbiter,
  output logic              ack1Arbiter,
  output logic [DATA_W-1:0] resultArbiter,
  output logic              statusArbiter,
  output logic              grantArbiter,
  output logic              busyArbiter
);

  state_t            state, state_next;
  logic [DATA_W-1:0] opA, opA_next;
  logic [DATA_W-1:0] opB, opB_next;
  logic [SEL_W-1:0]  opSel, opSel_next;
  logic              last, last_next;
  logic              ack0_next, ack1_next;
  logic [DATA_W-1:0] result_next;
  logic              status_next, grant_next, busy_next;

  logic              win;
  logic [DATA_W-1:0] ula_result, masked_result;
  logic              ula_status, masked_status;

  ULA u_ula (
    .a      (opA),
    .b      (opB),
    .sel    (opSel),
    .result (ula_result),
    .status (ula_status)
  );

  // Winner selection: round-robin on a tie when FAIR, otherwise requester 0 first.
  always_comb begin
    if (req0Arbiter && req1Arbiter) begin
      win = (FAIR != 0) ? ~last : 1'b0;
    end else begin
      win = ~req0Arbiter;
    end
  end

  // Force deterministic result/status per opcode regardless of ULA don't-care outputs.
  always_comb begin
    masked_result = ula_result;
    masked_status = 1'b0;
    case (opSel)
      IGUAL: begin
        masked_result = '0;
        masked_status = (opA == opB);
      end
      MAIOR, MENOR: begin
        masked_result = ula_result;
        masked_status = ula_status;
      end
      default: begin
        masked_result = ula_result;
        masked_status = 1'b0;
      end
    endcase
  end

  // Next-state and next-output logic; every register holds unless its state updates it.
  always_comb begin
    state_next  = state;
    opA_next    = opA;
    opB_next    = opB;
    opSel_next  = opSel;
    last_next   = last;
    ack0_next   = 1'b0;
    ack1_next   = 1'b0;
    result_next = resultArbiter;
    status_next = statusArbiter;
    grant_next  = grantArbiter;
    case (state)
      IDLE: begin
        if (req0Arbiter || req1Arbiter) begin
          grant_next = win;
          opA_next   = win ? a1Arbiter   : a0Arbiter;
          opB_next   = win ? b1Arbiter   : b0Arbiter;
          opSel_next = win ? sel1Arbiter : sel0Arbiter;
          state_next = EXEC;
        end
      end
      EXEC: begin
        result_next = masked_result;
        status_next = masked_status;
        ack0_next   = ~grantArbiter;
        ack1_next   = grantArbiter;
        state_next  = DONE;
      end
      DONE: begin
        last_next  = grantArbiter;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next != IDLE);
  end

  // State and output registers.
  always_ff @(posedge clockArbiter or posedge resetArbiter) begin
    if (resetArbiter) begin
      state         <= IDLE;
      opA           <= '0;
      opB           <= '0;
      opSel         <= '0;
      last          <= 1'b1;
      ack0Arbiter   <= 1'b0;
      ack1Arbiter   <= 1'b0;
      resultArbiter <= '0;
      statusArbiter <= 1'b0;
      grantArbiter  <= 1'b0;
      busyArbiter   <= 1'b0;
    end else begin
      state         <= state_next;
      opA           <= opA_next;
      opB           <= opB_next;
      opSel         <= opSel_next;
      last          <= last_next;
      ack0Arbiter   <= ack0_next;
      ack1Arbiter   <= ack1_next;
      resultArbiter <= result_next;
      statusArbiter <= status_next;
      grantArbiter  <= grant_next;
      busyArbiter   <= busy_next;
    end
  end

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares the single combinational 4-bit `ULA` between two requesters (for example the datapath sequencer and a debug/test port) using a registered request/acknowledge handshake. Each granted request is latched, executed on the `ULA` and returned as a registered result with a one-cycle acknowledge. The block owns the only `ULA` instance in its subsystem. It also makes `resultArbiter` and `statusArbiter` deterministic for opcodes where the `ULA` leaves an output unassigned.

## Interface
Parameters:
- `FAIR`, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, where requester 0 always wins.

Ports:
- `clockArbiter`  in  1  single clock; rising edge.
- `resetArbiter`  in  1  asynchronous, active-high reset.
- `req0Arbiter`  in  1  request from requester 0; held until `ack0Arbiter`.
- `a0Arbiter`  in  4  operand A, requester 0.
- `b0Arbiter`  in  4  operand B, requester 0.
- `sel0Arbiter`  in  3  opcode, requester 0.
- `req1Arbiter`, `a1Arbiter`, `b1Arbiter`, `sel1Arbiter`  in  1/4/4/3  same meanings for requester 1.
- `ack0Arbiter`  out  1  one-cycle pulse: result for requester 0 is valid.
- `ack1Arbiter`  out  1  one-cycle pulse: result for requester 1 is valid.
- `resultArbiter`  out  4  registered result; holds its value until the next completion.
- `statusArbiter`  out  1  registered comparison flag; holds its value until the next completion.
- `grantArbiter`  out  1  index of the requester owning the current or last operation.
- `busyArbiter`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - If any request is high, arbitrate and set `grantArbiter`.
  - Latch the winner's a/b/sel into the internal registers `opA`, `opB`, `opSel`, then go to EXEC.
  - If no request is high, stay in IDLE.
- EXEC:
  - The `ULA` is driven only from the latched registers.
  - On the next edge, capture the masked result into `resultArbiter`/`statusArbiter`, set the granted ack, then go to DONE.
- DONE:
  - Clear the ack, update the last-served pointer, go to IDLE.
- Arbitration:
  - `FAIR=1`: with both requests high, grant the requester not last served. The pointer resets to 1, so requester 0 wins the first tie.
  - `FAIR=0`: requester 0 always wins a tie.
  - With a single request, that requester is granted.
- Masking rules (opcodes 000–111 = ADD, SUB, COMP, IGUAL, MAIOR, MENOR, AND, OR):
  - ADD, SUB, COMP, AND, OR: result = `ULA` output; status = 0.
  - IGUAL: result = 4'b0000; status = (A == B).
  - MAIOR / MENOR: result and status both taken from the `ULA`.
- Arithmetic:
  - All results are 4 bits and wrap modulo 16; carry and borrow are dropped.
  - COMP = two's complement of B; A is ignored.
- Request inputs and operands seen outside IDLE are ignored. Operand changes during EXEC do not affect the in-flight operation.

## Timing
- Reset values (asynchronous, applied immediately):
  - state = IDLE.
  - `ack0Arbiter` = `ack1Arbiter` = 0.
  - `resultArbiter` = 4'b0000, `statusArbiter` = 0.
  - `grantArbiter` = 0, `busyArbiter` = 0.
  - last-served pointer = 1.
  - Latched operand registers = 0.
- Latency:
  - Request sampled at edge k.
  - Result and ack register at edge k+1; the ack is high for the cycle k+1 to k+2.
  - IDLE again at edge k+2.
  - Next arbitration at edge k+3.
  - Maximum throughput: one operation per 3 cycles.
- Handshake rules:
  - A requester keeps req and operands stable until it sees its ack.
  - It must drop req before edge k+3, or it is granted again.
  - Exactly one ack pulse is issued per grant.
  - The two acks are never high together.
- Simultaneous events: both requests rising in the same cycle are resolved by the arbitration rule; the loser stays pending and is served next, after 3 cycles.
- Reset mid-operation: the in-flight operation is discarded, no ack is issued, and outputs return to their reset values.

## Structure
- Shared package `ula_pkg` holds:
  - opcode constants ADD..OR (3 bits);
  - state encoding IDLE = 2'b00, EXEC = 2'b01, DONE = 2'b10;
  - data width constant 4.
- One sub-module: the existing `ULA`, instantiated once and fed only from `opA`, `opB`, `opSel`.
- Masking and registers live in `ula_arbiter`.

## Test plan
- Single request: req0 with A=8, B=2, sel=ADD at edge k -> `ack0Arbiter` pulses in the cycle after edge k+1; result = 4'b1010, status = 0, `grantArbiter` = 0.
- Opcode sweep on requester 1 with A=8, B=2:
  - SUB -> 6; COMP -> 14; AND -> 0; OR -> 10.
  - IGUAL -> result 0, status 0.
  - MAIOR -> result 8, status 1.
  - MENOR -> result 2, status 0.
- Tie: req0 and req1 high together from reset and held until their acks:
  - `FAIR=1` -> grants alternate 0, 1, 0, with acks 3 cycles apart.
  - `FAIR=0` -> requester 0 is served while it holds req; requester 1 is granted only once req0 is low at arbitration.
- Wrap-around: A=15, B=1, ADD -> result 0. A=0, B=1, SUB -> result 15.
- Operand change during EXEC: A=3, B=3, IGUAL latched; A changes to 5 during EXEC -> status 1.
- Reset mid-operation: assert `resetArbiter` during EXEC -> no ack issued; all outputs return to reset values; first tie after release goes to requester 0.
